// File: rtl/onehot_sel_decoder.sv
// Registered binary-to-one-hot product-select decoder with ack/timeout hold.
// Define DECODE_DEBOUNCE_EN to require STABLE_CYC stable samples before a code is accepted.
module onehot_sel_decoder #(
    parameter int IN_W       = 4,
    parameter int OUT_N      = 9,
    parameter int HOLD_CYC   = 16,
    parameter int STABLE_CYC = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  code,
    input  logic             code_valid,
    input  logic             ack,
    output logic [OUT_N-1:0] y,
    output logic             y_valid,
    output logic             busy,
    output logic             err,
    output logic             timeout
);

    localparam int CNT_W = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam logic [IN_W:0]    CODE_LIM  = (IN_W + 1)'(OUT_N);

    if (OUT_N < 2 || OUT_N > 2 ** IN_W || STABLE_CYC < 1 || HOLD_CYC < 0) begin : g_bad_param
        $error("onehot_sel_decoder: illegal parameter combination");
    end

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state_q, state_d;
    logic [OUT_N-1:0] y_q, y_d;
    logic             err_q, err_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept_req;
    logic             in_range;

`ifdef DECODE_DEBOUNCE_EN
    localparam int STAB_W = $clog2(STABLE_CYC + 1);

    logic [STAB_W-1:0] stab_q, stab_d, stab_next;
    logic [IN_W-1:0]   last_q, last_d;

    // The qualifying edge consumes the count, so a repeated code must re-qualify.
    always_comb begin
        stab_d     = '0;
        stab_next  = '0;
        last_d     = last_q;
        accept_req = 1'b0;
        if (state_q == IDLE && code_valid) begin
            if (stab_q != '0 && code == last_q) begin
                stab_next = stab_q + 1'b1;
            end else begin
                stab_next = STAB_W'(1);
            end
            last_d = code;
            if (stab_next >= STAB_W'(STABLE_CYC)) begin
                accept_req = 1'b1;
            end else begin
                stab_d = stab_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stab_q <= '0;
            last_q <= '0;
        end else begin
            stab_q <= stab_d;
            last_q <= last_d;
        end
    end
`else
    assign accept_req = code_valid;
`endif

    assign in_range = {1'b0, code} < CODE_LIM;

    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_req) begin
                    if (in_range) begin
                        y_d     = OUT_N'(1) << code;
                        cnt_d   = '0;
                        state_d = ACTIVE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (ack) begin
                    state_d = IDLE;
                    y_d     = '0;
                    cnt_d   = '0;
                end else if (HOLD_CYC != 0) begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d   = IDLE;
                        y_d       = '0;
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                y_d     = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            y_q       <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

    assign y       = y_q;
    assign y_valid = (state_q == ACTIVE);
    assign busy    = (state_q == ACTIVE);
    assign err     = err_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_onehot_sel_decoder.sv
// Scoreboard bench for onehot_sel_decoder: directed vectors push expected outputs, a monitor pops and checks.
module tb_onehot_sel_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] code = '0;
    logic       code_valid = 1'b0;
    logic       ack = 1'b0;
    logic [8:0] y;
    logic       y_valid, busy, err, timeout;

    onehot_sel_decoder #(
        .IN_W(4),
        .OUT_N(9),
        .HOLD_CYC(16),
        .STABLE_CYC(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .code(code),
        .code_valid(code_valid),
        .ack(ack),
        .y(y),
        .y_valid(y_valid),
        .busy(busy),
        .err(err),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] y;
        logic       v;
        logic       b;
        logic       e;
        logic       t;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Monitor: one expected tuple per clock edge once stimulus has started.
    initial begin
        exp_t  ex;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                ex = exp_q.pop_front();
                nm = name_q.pop_front();
                n_cmp++;
                if (y !== ex.y || y_valid !== ex.v || busy !== ex.b || err !== ex.e || timeout !== ex.t) begin
                    n_bad++;
                    $display("FAIL %s: got y=%b v=%b b=%b e=%b t=%b, expected y=%b v=%b b=%b e=%b t=%b",
                             nm, y, y_valid, busy, err, timeout, ex.y, ex.v, ex.b, ex.e, ex.t);
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic cv, input logic [3:0] c, input logic a,
                       input logic [8:0] ey, input logic ee, input logic et, input string nm);
        exp_t ex;
        @(negedge clk);
        rst        = r;
        code_valid = cv;
        code       = c;
        ack        = a;
        ex.y = ey;
        ex.v = (ey != 9'd0);
        ex.b = (ey != 9'd0);
        ex.e = ee;
        ex.t = et;
        exp_q.push_back(ex);
        name_q.push_back(nm);
    endtask

    initial begin
        logic [8:0] oh;
        int         guard;

        cyc(1, 1, 4'd3, 0, 9'b000000000, 0, 0, "reset_0");
        cyc(1, 1, 4'd3, 0, 9'b000000000, 0, 0, "reset_1");

`ifndef DECODE_DEBOUNCE_EN
        cyc(0, 1, 4'd3, 0, 9'b000001000, 0, 0, "post_reset_accept3");
        cyc(0, 0, 4'd0, 1, 9'b000000000, 0, 0, "post_reset_ack");
        cyc(0, 0, 4'd0, 1, 9'b000000000, 0, 0, "ack_in_idle");

        // Decode sweep; each new code lands on the edge right after the previous ack.
        for (int i = 0; i < 9; i++) begin
            oh = 9'd1 << i;
            cyc(0, 1, 4'(i), 0, oh, 0, 0, "sweep_accept");
            cyc(0, 0, 4'd0, 0, oh, 0, 0, "sweep_hold");
            cyc(0, 0, 4'd0, 1, 9'b000000000, 0, 0, "sweep_ack");
        end

        cyc(0, 1, 4'd9,  0, 9'b000000000, 1, 0, "oor_9_err");
        cyc(0, 0, 4'd0,  0, 9'b000000000, 0, 0, "oor_9_clear");
        cyc(0, 1, 4'd15, 0, 9'b000000000, 1, 0, "oor_15_err");
        cyc(0, 0, 4'd0,  0, 9'b000000000, 0, 0, "oor_15_clear");
        cyc(0, 1, 4'd4,  0, 9'b000010000, 0, 0, "after_oor_accept4");
        cyc(0, 0, 4'd0,  1, 9'b000000000, 0, 0, "after_oor_ack");

        // No ack: 16 cycles of y, then one-cycle timeout with y=0.
        cyc(0, 1, 4'd2, 0, 9'b000000100, 0, 0, "to_accept2");
        for (int j = 1; j < 16; j++) cyc(0, 0, 4'd0, 0, 9'b000000100, 0, 0, "to_hold");
        cyc(0, 0, 4'd0, 0, 9'b000000000, 0, 1, "to_pulse");
        cyc(0, 0, 4'd0, 0, 9'b000000000, 0, 0, "to_pulse_end");

        cyc(0, 1, 4'd2, 0, 9'b000000100, 0, 0, "ackwin_accept2");
        for (int j = 1; j < 16; j++) cyc(0, 0, 4'd0, 0, 9'b000000100, 0, 0, "ackwin_hold");
        cyc(0, 0, 4'd0, 1, 9'b000000000, 0, 0, "ackwin_no_timeout");
        cyc(0, 0, 4'd0, 0, 9'b000000000, 0, 0, "ackwin_idle");

        cyc(0, 1, 4'd1,  0, 9'b000000010, 0, 0, "busy_accept1");
        cyc(0, 1, 4'd7,  0, 9'b000000010, 0, 0, "busy_ignore7");
        cyc(0, 1, 4'd12, 0, 9'b000000010, 0, 0, "busy_ignore12_no_err");
        cyc(0, 0, 4'd0,  1, 9'b000000000, 0, 0, "busy_ack");
        cyc(0, 1, 4'd7,  0, 9'b010000000, 0, 0, "busy_then_accept7");
        cyc(0, 0, 4'd0,  1, 9'b000000000, 0, 0, "busy_ack7");

        cyc(0, 1, 4'd5, 0, 9'b000100000, 0, 0, "midrst_accept5");
        cyc(1, 0, 4'd0, 0, 9'b000000000, 0, 0, "midrst_drop");
        cyc(0, 0, 4'd0, 0, 9'b000000000, 0, 0, "midrst_idle");
`else
        cyc(0, 1, 4'd5, 0, 9'b000000000, 0, 0, "db_code5_a");
        cyc(0, 1, 4'd5, 0, 9'b000000000, 0, 0, "db_code5_b");
        cyc(0, 1, 4'd6, 0, 9'b000000000, 0, 0, "db_code6_a");
        cyc(0, 1, 4'd6, 0, 9'b000000000, 0, 0, "db_code6_b");
        cyc(0, 1, 4'd6, 0, 9'b001000000, 0, 0, "db_code6_accept");
        cyc(0, 0, 4'd0, 1, 9'b000000000, 0, 0, "db_ack");
        cyc(0, 1, 4'd9, 0, 9'b000000000, 0, 0, "db_oor_a");
        cyc(0, 1, 4'd9, 0, 9'b000000000, 0, 0, "db_oor_b");
        cyc(0, 1, 4'd9, 0, 9'b000000000, 1, 0, "db_oor_err");
        cyc(0, 0, 4'd0, 0, 9'b000000000, 0, 0, "db_idle");
`endif

        @(negedge clk);
        code_valid = 1'b0;
        ack        = 1'b0;
        guard      = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/onehot_sel_decoder.md
# onehot_sel_decoder

Registered, parametrised binary-to-one-hot selection decoder for the vending machine product-select path. It accepts a binary item code with a valid strobe and drives a held one-hot select vector (default 9 lines from a 4-bit code) to the dispense logic. The vector stays asserted until the consumer acknowledges it or a hold timeout expires. Out-of-range codes are rejected with an error pulse, and new codes are ignored while a selection is active.

## Interface
Parameters:
- IN_W, 4, width of the binary code input.
- OUT_N, 9, number of one-hot output lines; legal range 2..2**IN_W.
- HOLD_CYC, 16, maximum cycles a selection is held without ack; 0 disables the timeout.
- STABLE_CYC, 3, consecutive stable cycles required before a code is accepted; used only with DECODE_DEBOUNCE_EN, legal range ≥1.

Ports:
- clk  in  1  rising-edge clock; the block uses one clock.
- rst  in  1  synchronous, active-high reset.
- code  in  IN_W  binary item code.
- code_valid  in  1  code is presented this cycle.
- ack  in  1  consumer has taken the selection.
- y  out  OUT_N  one-hot select vector; all zero when no selection is active.
- y_valid  out  1  y holds an active selection.
- busy  out  1  block is in ACTIVE; code_valid is ignored.
- err  out  1  one-cycle pulse: out-of-range code was rejected.
- timeout  out  1  one-cycle pulse: the selection expired without ack.

## Operation
- Reset: state=IDLE, y=0, y_valid=0, busy=0, err=0, timeout=0, hold counter=0, debounce state cleared. Reset asserted mid-selection drops y on the next edge with no timeout or err pulse.
- State IDLE:
  - code_valid=1 with code<OUT_N: load y = 1<<code, clear the hold counter, go to ACTIVE.
  - code_valid=1 with code≥OUT_N: err=1 for one cycle, y stays 0, remain in IDLE.
- State ACTIVE: y, y_valid=1 and busy=1 are held constant. code_valid and code are ignored; they produce no err and are not queued.
  - ack=1: go to IDLE, clearing y.
  - ack=0 with HOLD_CYC≠0: increment the counter. When the counter equals HOLD_CYC-1 at an edge, go to IDLE, clear y, and pulse timeout=1.
  - ack and the expiry condition in the same cycle: ack wins and timeout stays 0.
  - HOLD_CYC=0: the block stays in ACTIVE until ack.
- ack received in IDLE has no effect.
- Invariants:
  - y is all zero or exactly one-hot.
  - y_valid equals |y, which equals busy.
  - err and timeout are never high in the same cycle.
- Counter width: $clog2(HOLD_CYC+1), with a minimum of 1.

## Timing
- Acceptance latency is 1 cycle. code_valid sampled at edge k in IDLE gives y/y_valid/busy high from edge k.
- err asserts from edge k and clears at edge k+1.
- Release latency is 1 cycle. ack sampled at edge m clears y from edge m.
- A new code can be accepted at edge m+1 at the earliest.
- Without ack, y_valid stays high for exactly HOLD_CYC cycles. timeout is high during the first cycle in which y=0.
- Outputs are registered and have no combinational input-to-output path.

## Configuration
- DECODE_DEBOUNCE_EN defined:
  - A code is accepted in IDLE only after code_valid=1 with an unchanged code for STABLE_CYC consecutive sampled edges. Acceptance latency is therefore STABLE_CYC cycles.
  - A change of code, or code_valid=0, restarts the stability count.
  - The range check, and err if the code is out of range, happens only on the qualifying edge.
  - The stability count is held cleared while in ACTIVE.
- DECODE_DEBOUNCE_EN undefined: single-edge acceptance as described above. STABLE_CYC is ignored and the debounce logic is not synthesised.

## Test plan
- Reset: drive rst=1 for 2 cycles with code_valid=1, code=3 → y=0, y_valid=0, busy=0, err=0, timeout=0 throughout; after rst falls, code 3 is accepted on the next edge and y=9'b000001000.
- Full decode sweep: apply codes 0..8, each followed by ack 2 cycles later → y=1<<code, one-hot, 1-cycle latency; y clears the edge after ack.
- Out of range: apply code=9 and code=15 in IDLE → err high for exactly 1 cycle each, y=0, busy=0; code=4 applied afterwards gives y=9'b000010000.
- Timeout with HOLD_CYC=16: accept code 2 with no ack → y_valid high for exactly 16 cycles, then y=0 and a 1-cycle timeout pulse. Repeat with ack arriving on the expiry cycle → no timeout pulse.
- Busy ignore: accept code 1, then apply code_valid with code 7 and with code 12 while ACTIVE → y stays 9'b000000010 and err=0; after ack, code 7 is accepted.
- With DECODE_DEBOUNCE_EN and STABLE_CYC=3: code 5 held for 2 cycles then changed to 6 and held for 3 cycles → code 5 is never accepted; y=9'b001000000 appears 3 cycles after 6 first appears.
